// File: rtl/spi_slave_cmd_parser.sv
// SPI slave command front end: deserialises opcode/address/data in single or QPI mode,
// drives the register-file port and memory word stream, and serialises read data on sdo.
module spi_slave_cmd_parser (
  input  logic        sclk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic [3:0]  sdi,
  input  logic        en_qpi,
  input  logic [7:0]  dummy_cycles,
  input  logic [7:0]  reg_rd_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid,
  output logic [1:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        reg_wr_valid,
  output logic [1:0]  reg_rd_addr,
  output logic [31:0] mem_addr,
  output logic        mem_addr_valid,
  output logic [31:0] mem_wdata,
  output logic        mem_wdata_valid,
  output logic        mem_rd_req,
  output logic        mem_rd_underrun,
  output logic [3:0]  sdo,
  output logic        sdo_oe
);

  typedef enum logic [3:0] {
    CMD, ADDR, DUMMY, WDATA, RDATA, REGW, TURN, REGR, IGNORE
  } state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        qpi_reg, qpi_next;
  logic [7:0]  op_reg, op_next;
  logic [31:0] sh_in_reg, sh_in_next;
  logic [31:0] sh_out_reg, sh_out_next;

  logic [1:0]  reg_wr_addr_next;
  logic [7:0]  reg_wr_data_next;
  logic        reg_wr_valid_next;
  logic [1:0]  reg_rd_addr_next;
  logic [31:0] mem_addr_next;
  logic        mem_addr_valid_next;
  logic [31:0] mem_wdata_next;
  logic        mem_wdata_valid_next;
  logic        mem_rd_req_next;
  logic        mem_rd_underrun_next;
  logic [3:0]  sdo_next;
  logic        sdo_oe_next;

  logic        qpi;
  logic [31:0] sh_in_shift;
  logic [7:0]  last_byte;
  logic [7:0]  last_word;
  logic [7:0]  dummy_last;
  logic [31:0] rd_word;
  logic        load;
  logic [31:0] load_data;
  logic [31:0] out_src;
  logic        out_next;

  // The very first selected cycle in CMD uses the live en_qpi; afterwards the latched copy.
  assign qpi         = (state_reg == CMD && cnt_reg == 8'd0) ? en_qpi : qpi_reg;
  assign sh_in_shift = qpi ? {sh_in_reg[27:0], sdi} : {sh_in_reg[30:0], sdi[0]};
  assign last_byte   = qpi ? 8'd1 : 8'd7;
  assign last_word   = qpi ? 8'd7 : 8'd31;
  assign dummy_last  = (dummy_cycles == 8'd0) ? 8'd0 : dummy_cycles - 8'd1;
  assign rd_word     = mem_rdata_valid ? mem_rdata : 32'd0;

  always_comb begin
    state_next           = state_reg;
    cnt_next             = cnt_reg + 8'd1;
    qpi_next             = qpi_reg;
    op_next              = op_reg;
    sh_in_next           = sh_in_shift;
    reg_wr_addr_next     = reg_wr_addr;
    reg_wr_data_next     = reg_wr_data;
    reg_wr_valid_next    = 1'b0;
    reg_rd_addr_next     = reg_rd_addr;
    mem_addr_next        = mem_addr;
    mem_addr_valid_next  = 1'b0;
    mem_wdata_next       = mem_wdata;
    mem_wdata_valid_next = 1'b0;
    mem_rd_req_next      = 1'b0;
    mem_rd_underrun_next = 1'b0;
    load                 = 1'b0;
    load_data            = 32'd0;

    if (cs_n) begin
      state_next = CMD;
      cnt_next   = 8'd0;
      sh_in_next = 32'd0;
    end else begin
      if (state_reg == CMD && cnt_reg == 8'd0) qpi_next = en_qpi;
      case (state_reg)
        CMD: begin
          if (cnt_reg == last_byte) begin
            cnt_next   = 8'd0;
            sh_in_next = 32'd0;
            op_next    = sh_in_shift[7:0];
            if (sh_in_shift[7:3] == 5'b00010) begin
              if (sh_in_shift[2]) begin
                state_next       = TURN;
                reg_rd_addr_next = sh_in_shift[1:0];
              end else begin
                state_next = REGW;
              end
            end else if (sh_in_shift[7:0] == 8'h02 || sh_in_shift[7:0] == 8'h0B) begin
              state_next = ADDR;
            end else begin
              state_next = IGNORE;
            end
          end
        end
        ADDR: begin
          if (cnt_reg == last_word) begin
            cnt_next            = 8'd0;
            sh_in_next          = 32'd0;
            mem_addr_next       = sh_in_shift;
            mem_addr_valid_next = 1'b1;
            if (op_reg == 8'h0B) begin
              mem_rd_req_next = 1'b1;
              state_next      = DUMMY;
            end else begin
              state_next = WDATA;
            end
          end
        end
        WDATA: begin
          if (cnt_reg == last_word) begin
            cnt_next             = 8'd0;
            sh_in_next           = 32'd0;
            mem_wdata_next       = sh_in_shift;
            mem_wdata_valid_next = 1'b1;
          end
        end
        DUMMY: begin
          sh_in_next = 32'd0;
          if (cnt_reg == dummy_last) begin
            cnt_next             = 8'd0;
            load                 = 1'b1;
            load_data            = rd_word;
            mem_rd_underrun_next = ~mem_rdata_valid;
            state_next           = RDATA;
          end
        end
        RDATA: begin
          sh_in_next = 32'd0;
          if (cnt_reg == last_word) begin
            cnt_next             = 8'd0;
            load                 = 1'b1;
            load_data            = rd_word;
            mem_rd_underrun_next = ~mem_rdata_valid;
          end else if (cnt_reg == last_word - 8'd1) begin
            // Registered, so the request is high while the word's last bit is on sdo.
            mem_rd_req_next = 1'b1;
          end
        end
        REGW: begin
          if (cnt_reg == last_byte) begin
            cnt_next          = 8'd0;
            sh_in_next        = 32'd0;
            reg_wr_valid_next = 1'b1;
            reg_wr_addr_next  = op_reg[1:0];
            reg_wr_data_next  = sh_in_shift[7:0];
            state_next        = IGNORE;
          end
        end
        TURN: begin
          cnt_next   = 8'd0;
          sh_in_next = 32'd0;
          load       = 1'b1;
          load_data  = {reg_rd_data, 24'd0};
          state_next = REGR;
        end
        REGR: begin
          sh_in_next = 32'd0;
          if (cnt_reg == last_byte) begin
            cnt_next   = 8'd0;
            state_next = IGNORE;
          end
        end
        IGNORE: begin
          cnt_next   = cnt_reg;
          sh_in_next = sh_in_reg;
        end
        default: begin
          cnt_next   = 8'd0;
          sh_in_next = 32'd0;
          state_next = CMD;
        end
      endcase
    end
  end

  // sdo always shows the leading bits of out_src; sh_out keeps what remains.
  assign out_next = (state_next == REGR) || (state_next == RDATA);
  assign out_src  = load ? load_data : sh_out_reg;

  always_comb begin
    sdo_next    = 4'd0;
    sh_out_next = 32'd0;
    sdo_oe_next = out_next;
    if (out_next) begin
      if (qpi) begin
        sdo_next    = out_src[31:28];
        sh_out_next = {out_src[27:0], 4'd0};
      end else begin
        sdo_next    = {3'd0, out_src[31]};
        sh_out_next = {out_src[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_reg       <= CMD;
      cnt_reg         <= 8'd0;
      qpi_reg         <= 1'b0;
      op_reg          <= 8'd0;
      sh_in_reg       <= 32'd0;
      sh_out_reg      <= 32'd0;
      reg_wr_addr     <= 2'd0;
      reg_wr_data     <= 8'd0;
      reg_wr_valid    <= 1'b0;
      reg_rd_addr     <= 2'd0;
      mem_addr        <= 32'd0;
      mem_addr_valid  <= 1'b0;
      mem_wdata       <= 32'd0;
      mem_wdata_valid <= 1'b0;
      mem_rd_req      <= 1'b0;
      mem_rd_underrun <= 1'b0;
      sdo             <= 4'd0;
      sdo_oe          <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      qpi_reg         <= qpi_next;
      op_reg          <= op_next;
      sh_in_reg       <= sh_in_next;
      sh_out_reg      <= sh_out_next;
      reg_wr_addr     <= reg_wr_addr_next;
      reg_wr_data     <= reg_wr_data_next;
      reg_wr_valid    <= reg_wr_valid_next;
      reg_rd_addr     <= reg_rd_addr_next;
      mem_addr        <= mem_addr_next;
      mem_addr_valid  <= mem_addr_valid_next;
      mem_wdata       <= mem_wdata_next;
      mem_wdata_valid <= mem_wdata_valid_next;
      mem_rd_req      <= mem_rd_req_next;
      mem_rd_underrun <= mem_rd_underrun_next;
      sdo             <= sdo_next;
      sdo_oe          <= sdo_oe_next;
    end
  end

endmodule

// File: tb/tb_spi_slave_cmd_parser.sv
// Directed bench for spi_slave_cmd_parser: expected values are queued when stimulus
// is driven and popped when the corresponding DUT output is observed.
module tb_spi_slave_cmd_parser;

  logic        sclk;
  logic        rst;
  logic        cs_n;
  logic [3:0]  sdi;
  logic        en_qpi;
  logic [7:0]  dummy_cycles;
  logic [7:0]  reg_rd_data;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic [1:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic        reg_wr_valid;
  logic [1:0]  reg_rd_addr;
  logic [31:0] mem_addr;
  logic        mem_addr_valid;
  logic [31:0] mem_wdata;
  logic        mem_wdata_valid;
  logic        mem_rd_req;
  logic        mem_rd_underrun;
  logic [3:0]  sdo;
  logic        sdo_oe;

  spi_slave_cmd_parser dut (
    .sclk(sclk), .rst(rst), .cs_n(cs_n), .sdi(sdi), .en_qpi(en_qpi),
    .dummy_cycles(dummy_cycles), .reg_rd_data(reg_rd_data),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .reg_wr_valid(reg_wr_valid),
    .reg_rd_addr(reg_rd_addr), .mem_addr(mem_addr), .mem_addr_valid(mem_addr_valid),
    .mem_wdata(mem_wdata), .mem_wdata_valid(mem_wdata_valid), .mem_rd_req(mem_rd_req),
    .mem_rd_underrun(mem_rd_underrun), .sdo(sdo), .sdo_oe(sdo_oe)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Register-file stand-in: combinational read on reg_rd_addr.
  logic [7:0] rf [4];
  assign reg_rd_data = rf[reg_rd_addr];

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ctrl;
  logic        activity;
  assign ctrl = {18'd0, reg_wr_valid, reg_wr_addr, reg_rd_addr, mem_addr_valid,
                 mem_wdata_valid, mem_rd_req, mem_rd_underrun, sdo, sdo_oe};
  assign activity = reg_wr_valid | mem_addr_valid | mem_wdata_valid | mem_rd_req |
                    mem_rd_underrun | sdo_oe | (|sdo);

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h required a queued entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic shift_in(input logic [31:0] val, input int nbits, input bit q);
    if (q) begin
      for (int i = nbits / 4 - 1; i >= 0; i--) begin
        sdi = val[i*4 +: 4];
        tick();
      end
    end else begin
      for (int i = nbits - 1; i >= 0; i--) begin
        sdi = {3'b000, val[i]};
        tick();
      end
    end
    sdi = 4'd0;
  endtask

  initial begin
    logic [31:0] word;
    int          cnt;
    logic        req_last;
    logic [3:0]  hi_or;

    rf[0] = 8'h00; rf[1] = 8'h00; rf[2] = 8'h3C; rf[3] = 8'h00;
    rst = 1'b1; cs_n = 1'b1; sdi = 4'd0; en_qpi = 1'b0; dummy_cycles = 8'd0;
    mem_rdata = 32'd0; mem_rdata_valid = 1'b0;
    repeat (3) tick();

    // Reset state
    push("reset_ctrl", 32'd0);        chk(ctrl);
    push("reset_mem_addr", 32'd0);    chk(mem_addr);
    push("reset_mem_wdata", 32'd0);   chk(mem_wdata);
    push("reset_reg_wr_data", 32'd0); chk({24'd0, reg_wr_data});
    rst = 1'b0;
    tick();

    // Register write, single mode: 0x11 then 0xA5
    cs_n = 1'b0;
    push("w1_valid", 32'd1); push("w1_addr", 32'd1); push("w1_data", 32'hA5);
    shift_in(32'h11, 8, 1'b0);
    shift_in(32'hA5, 8, 1'b0);
    chk({31'd0, reg_wr_valid}); chk({30'd0, reg_wr_addr}); chk({24'd0, reg_wr_data});
    tick();
    push("w1_pulse_len", 32'd0); chk({31'd0, reg_wr_valid});
    cs_n = 1'b1; tick();

    // Write reg0 = 0x01 single, then QPI register read of reg2
    cs_n = 1'b0;
    push("w0_valid", 32'd1); push("w0_addr", 32'd0); push("w0_data", 32'h01);
    shift_in(32'h10, 8, 1'b0);
    shift_in(32'h01, 8, 1'b0);
    chk({31'd0, reg_wr_valid}); chk({30'd0, reg_wr_addr}); chk({24'd0, reg_wr_data});
    cs_n = 1'b1; en_qpi = 1'b1; tick();
    cs_n = 1'b0;
    push("rr_turn_addr", 32'd2); push("rr_turn_oe", 32'd0);
    shift_in(32'h16, 8, 1'b1);
    chk({30'd0, reg_rd_addr}); chk({31'd0, sdo_oe});
    tick();
    push("rr_nib_hi", 32'h3); push("rr_oe_hi", 32'd1);
    chk({28'd0, sdo}); chk({31'd0, sdo_oe});
    tick();
    push("rr_nib_lo", 32'hC); push("rr_oe_lo", 32'd1);
    chk({28'd0, sdo}); chk({31'd0, sdo_oe});
    tick();
    push("rr_oe_done", 32'd0); chk({31'd0, sdo_oe});
    cs_n = 1'b1; tick();

    // Memory write, QPI
    cs_n = 1'b0;
    push("mw_addr_valid", 32'd1); push("mw_addr", 32'h1000_0004); push("mw_no_rd_req", 32'd0);
    shift_in(32'h02, 8, 1'b1);
    shift_in(32'h1000_0004, 32, 1'b1);
    chk({31'd0, mem_addr_valid}); chk(mem_addr); chk({31'd0, mem_rd_req});
    push("mw_w0_valid", 32'd1); push("mw_w0_data", 32'hDEAD_BEEF);
    shift_in(32'hDEAD_BEEF, 32, 1'b1);
    chk({31'd0, mem_wdata_valid}); chk(mem_wdata);
    push("mw_w1_valid", 32'd1); push("mw_w1_data", 32'h0123_4567);
    shift_in(32'h0123_4567, 32, 1'b1);
    chk({31'd0, mem_wdata_valid}); chk(mem_wdata);
    cs_n = 1'b1; tick();
    push("mw_valid_end", 32'd0); chk({31'd0, mem_wdata_valid});

    // Memory read, single mode, 4 dummy cycles
    en_qpi = 1'b0; dummy_cycles = 8'd4;
    mem_rdata = 32'h8000_0001; mem_rdata_valid = 1'b1;
    cs_n = 1'b0;
    push("mr_addr_valid", 32'd1); push("mr_rd_req", 32'd1); push("mr_addr", 32'h0000_0040);
    shift_in(32'h0B, 8, 1'b0);
    shift_in(32'h0000_0040, 32, 1'b0);
    chk({31'd0, mem_addr_valid}); chk({31'd0, mem_rd_req}); chk(mem_addr);
    repeat (3) tick();
    push("mr_dummy_oe", 32'd0); chk({31'd0, sdo_oe});
    tick();
    push("mr_first_bit", 32'd1); push("mr_first_oe", 32'd1); push("mr_no_underrun", 32'd0);
    chk({28'd0, sdo}); chk({31'd0, sdo_oe}); chk({31'd0, mem_rd_underrun});
    word = 32'd0; word[31] = sdo[0]; cnt = 0; req_last = 1'b0; hi_or = 4'd0;
    for (int k = 30; k >= 0; k--) begin
      tick();
      word[k] = sdo[0];
      hi_or = hi_or | {1'b0, sdo[3:1]};
      if (mem_rd_req) cnt++;
      if (k == 0) req_last = mem_rd_req;
    end
    push("mr_word", 32'h8000_0001); push("mr_req_on_last", 32'd1);
    push("mr_req_count", 32'd1);    push("mr_upper_lines", 32'd0);
    chk(word); chk({31'd0, req_last}); chk(cnt); chk({28'd0, hi_or});

    // Underrun on the next word
    mem_rdata_valid = 1'b0;
    tick();
    push("ur_pulse", 32'd1); push("ur_oe", 32'd1);
    chk({31'd0, mem_rd_underrun}); chk({31'd0, sdo_oe});
    word = 32'd0; word[31] = sdo[0]; cnt = 0;
    for (int k = 30; k >= 0; k--) begin
      tick();
      word[k] = sdo[0];
      if (mem_rd_underrun) cnt++;
    end
    push("ur_word_zero", 32'd0); push("ur_pulse_count", 32'd0);
    chk(word); chk(cnt);
    cs_n = 1'b1; tick();
    push("ur_oe_after_cs", 32'd0); chk({31'd0, sdo_oe});

    // Abort after 20 of 32 write bits, then prove CMD by a register write
    cs_n = 1'b0;
    push("ab_addr_valid", 32'd1);
    shift_in(32'h02, 8, 1'b0);
    shift_in(32'h2000_0000, 32, 1'b0);
    chk({31'd0, mem_addr_valid});
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      sdi = {3'b000, 1'($urandom_range(0, 1))};
      tick();
      if (mem_wdata_valid) cnt++;
    end
    cs_n = 1'b1; tick();
    if (mem_wdata_valid) cnt++;
    tick();
    if (mem_wdata_valid) cnt++;
    push("ab_no_wdata", 32'd0); chk(cnt);
    cs_n = 1'b0;
    push("ab_w_valid", 32'd1); push("ab_w_addr", 32'd3); push("ab_w_data", 32'h5A);
    shift_in(32'h13, 8, 1'b0);
    shift_in(32'h5A, 8, 1'b0);
    chk({31'd0, reg_wr_valid}); chk({30'd0, reg_wr_addr}); chk({24'd0, reg_wr_data});
    cs_n = 1'b1; tick();

    // Bad opcode: nothing until cs_n rises
    cs_n = 1'b0;
    shift_in(32'hFF, 8, 1'b0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      sdi = 4'($urandom_range(0, 15));
      tick();
      if (activity) cnt++;
    end
    push("bad_op_quiet", 32'd0); chk(cnt);
    cs_n = 1'b1; sdi = 4'd0; tick();

    // Reset mid-read, dummy_cycles = 0 behaves as 1
    dummy_cycles = 8'd0; mem_rdata = 32'hFFFF_FFFF; mem_rdata_valid = 1'b1;
    cs_n = 1'b0;
    push("rs_rd_req", 32'd1);
    shift_in(32'h0B, 8, 1'b0);
    shift_in(32'h0000_0100, 32, 1'b0);
    chk({31'd0, mem_rd_req});
    tick();
    push("rs_dummy0_bit", 32'd1); push("rs_dummy0_oe", 32'd1);
    chk({28'd0, sdo}); chk({31'd0, sdo_oe});
    rst = 1'b1;
    tick();
    push("rs_ctrl", 32'd0); push("rs_mem_addr", 32'd0);
    push("rs_mem_wdata", 32'd0); push("rs_reg_wr_data", 32'd0);
    chk(ctrl); chk(mem_addr); chk(mem_wdata); chk({24'd0, reg_wr_data});
    rst = 1'b0; cs_n = 1'b1;
    tick();

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_cmd_parser.md
# spi_slave_cmd_parser

Serial-side command front end of the SPI slave, clocked by `sclk`. It deserialises opcode, address and data bits in single-bit or QPI mode, and drives the configuration-register write/read port of the SPI register file. It also issues memory address/data words toward the AXI side and serialises read data back out on `sdo`. It consumes the register file's `en_qpi` and `dummy_cycles` outputs.

## Interface
- No parameters; widths are fixed: opcode 8, address 32, memory word 32, register 8.
- `sclk` in 1: the only clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `cs_n` in 1: chip select, active-low, sampled on `sclk`.
- `sdi` in 4: serial input. Single mode uses only `sdi[0]`. QPI mode uses all four lines, MSB nibble first.
- `en_qpi` in 1: QPI enable from the register file.
- `dummy_cycles` in 8: number of memory-read dummy cycles, from the register file.
- `reg_rd_data` in 8: register file read data, combinational on `reg_rd_addr`.
- `mem_rdata` in 32: memory read word.
- `mem_rdata_valid` in 1: `mem_rdata` holds valid data.
- `reg_wr_addr` out 2, `reg_wr_data` out 8, `reg_wr_valid` out 1: register write port.
- `reg_rd_addr` out 2: register read address.
- `mem_addr` out 32, `mem_addr_valid` out 1: memory transfer start address, with a one-cycle pulse.
- `mem_wdata` out 32, `mem_wdata_valid` out 1: memory write word, with a one-cycle pulse.
- `mem_rd_req` out 1: one-cycle pulse requesting the next read word.
- `mem_rd_underrun` out 1: one-cycle pulse when a read word was needed but unavailable.
- `sdo` out 4, `sdo_oe` out 1: serial output and its output enable.

## Operation
- **Opcodes** (8 bits, MSB first):
  - `0001_00aa`: write register `aa`.
  - `0001_01aa`: read register `aa`.
  - `0x02`: memory write.
  - `0x0B`: memory read.
  - Any other value sends the FSM to IGNORE.
- **Mode latch:** `en_qpi` is latched on the first cycle with `cs_n` low while in CMD. It is held for the whole transaction, so a QPI enable/disable takes effect from the next transaction.
- **Bits per cycle:** 1 in single mode, 4 in QPI mode. Cycles per field: opcode 8/2, address 32/8, word 32/8, register 8/2 (single/QPI).
- **States:** CMD, ADDR, DUMMY, WDATA, RDATA, REGW, TURN, REGR, IGNORE.
- **Transitions:**
  - CMD → REGW / TURN / ADDR / IGNORE, according to the opcode.
  - REGW: after 8 data bits, pulse `reg_wr_valid` with `reg_wr_addr = aa`, then go to IGNORE.
  - TURN (exactly 1 cycle, register reads only): `reg_rd_addr = aa` is driven from TURN entry. `reg_rd_data` is loaded into the output shifter at the end of TURN, then go to REGR. REGR shifts out 8 bits, then goes to IGNORE.
  - ADDR: when complete, drive `mem_addr` and pulse `mem_addr_valid`. Write → WDATA. Read → also pulse `mem_rd_req`, then DUMMY.
  - WDATA: each complete 32-bit word drives `mem_wdata` and pulses `mem_wdata_valid`, then WDATA repeats.
  - DUMMY: lasts max(`dummy_cycles`, 1) cycles. On the last cycle, load the output shifter with `mem_rdata` if `mem_rdata_valid`, else with 0 and pulse `mem_rd_underrun`. Then go to RDATA.
  - RDATA: shifts the word out. On the cycle the last bit of a word is driven, pulse `mem_rd_req` and reload the shifter per the DUMMY rule.
  - IGNORE: stays until `cs_n` goes high.
- **`cs_n` high** on any cycle returns the FSM to CMD and clears counters and shifters. A partial word or register byte is discarded with no valid pulse, and `sdo_oe` goes to 0.
- **Serial output:** `sdo_oe` is 1 only in REGR and RDATA. Single mode drives `sdo[0]` with `sdo[3:1] = 0`. QPI drives the MSB nibble first.

## Timing
- All outputs are registered.
- **Reset values:** FSM = CMD; all outputs 0, including `reg_rd_addr`, `mem_addr`, `mem_wdata` and `sdo`.
- **Pulse latency:** valid pulses (`reg_wr_valid`, `mem_addr_valid`, `mem_wdata_valid`, `mem_rd_req`) assert in the cycle after the edge that sampled the last bit, and last exactly 1 cycle.
- **Register read:** after the opcode's last sampled edge, there is 1 TURN cycle. The first output bit is valid on the following cycle.
- **Memory read:** the first data bit is driven the cycle after the last DUMMY cycle. `dummy_cycles = 0` behaves as 1.
- **`rst` vs `cs_n`:** `rst` has priority over `cs_n`.
- **Address/word widths:** the address does not increment internally; the downstream block owns address incrementing and wrapping. Word counts are unbounded; there is no overflow.

## Test plan
- **Register write, single mode:** `cs_n` low, opcode `0x11`, data `0xA5` (16 cycles) → one `reg_wr_valid` pulse with addr 1, data `0xA5`, at cycle 17.
- **Register write, then QPI transaction:** write reg0 = `0x01`, raise `cs_n` for 1 cycle, tie `en_qpi` = 1 → next opcode is accepted in 2 cycles. Register read `0x16` → `reg_rd_addr = 2` in TURN; `reg_rd_data = 0x3C` appears as nibbles 3 then C, with `sdo_oe` = 1.
- **Memory write, QPI:** opcode `0x02`, address `0x1000_0004`, two words `0xDEADBEEF` and `0x01234567` → one `mem_addr_valid` pulse, then two `mem_wdata_valid` pulses 8 cycles apart with correct data.
- **Memory read, single mode:** `dummy_cycles = 4`, `mem_rdata = 0x8000_0001` valid → `mem_rd_req` pulse at address done. First `sdo[0]` = 1 exactly 5 cycles after the address completes. Second `mem_rd_req` pulse on the 32nd output bit.
- **Read underrun:** `mem_rdata_valid` = 0 at the end of DUMMY → `mem_rd_underrun` pulses and 32 zero bits are shifted out.
- **Abort, bad opcode and reset:** `cs_n` high after 20 of 32 WDATA bits → no `mem_wdata_valid`, FSM back in CMD. Opcode `0xFF` → no outputs until `cs_n` goes high. `rst` mid-read → all outputs 0 on the next cycle.
